usb_uart_tx_batcher: RTL and testbench
======================================

// Module: usb_uart_tx_batcher
// PURPOSE
//  Byte FIFO and packet-batching stage directly upstream of usb_uart's uart_in_* pipeline (device->host).
//  Buffers bytes from user logic and releases them in bursts, so the USB bulk-IN side sees full-ish packets, not 1-byte ones.
//  Release happens at a fill threshold, after an idle timeout, or on flush. Output is a valid/ready stream wired to uart_in_*.
// PARAMETERS
//  DEPTH      64     FIFO entries; power of 2, >=2
//  THRESHOLD  32     fill level (1..DEPTH) that starts a drain; 1 = no batching
//  TIMEOUT    48000  idle cycles after the last accepted write before a drain starts (1 ms @ 48 MHz); >=1
// PORTS
//  clk_48mhz  in   1            sole clock
//  reset      in   1            synchronous, ACTIVE-LOW (0 = reset)
//  in_data    in   8            byte from user logic
//  in_valid   in   1            in_data valid
//  in_ready   out  1            FIFO can accept; transfer when in_valid&&in_ready
//  flush      in   1            level-sensitive request to drain now
//  out_data   out  8            to usb_uart.uart_in_data
//  out_valid  out  1            to usb_uart.uart_in_valid
//  out_ready  in   1            from usb_uart.uart_in_ready
//  level      out  $clog2(DEPTH)+1  FIFO entries held, excluding output register (0..DEPTH)
// BEHAVIOUR
//  Reset (reset==0 at edge): wr/rd pointers=0, level=0, out_valid=0, out_data=8'h00, timer=0, state=IDLE.
//   in_ready=0 while reset==0. A mid-operation reset discards all contents; out_valid drops at that edge.
//  Storage: circular, pointers carry an extra wrap bit; full = DEPTH entries; in_ready = !full (registered-state derived).
//   No write-through when full, even with a same-cycle read. No empty bypass: a byte written at edge N is readable after N.
//  Output register (ob): out_data/out_valid are registered. ob loads mem[rd_ptr] when state==DRAIN, FIFO non-empty and (!out_valid || out_ready).
//   Once out_valid=1, out_data is held stable until out_ready=1. Back-to-back bytes sustain 1 byte/cycle while out_ready=1.
//   Min latency, write accepted at edge N with state already DRAIN: out_valid=1 after edge N+1.
//  FSM states IDLE / HOLD / DRAIN:
//   IDLE : FIFO and ob empty. Accepted write -> HOLD; timer=0.
//   HOLD : timer=0 on each accepted write, else timer+1 (saturating, width $clog2(TIMEOUT+1)).
//          -> DRAIN when level>=THRESHOLD (level after this edge's write), or timer==TIMEOUT-1 with no write this cycle, or flush==1.
//   DRAIN: writes are still accepted and drained in the same burst.
//          -> IDLE when FIFO empty, no write this cycle, and (ob empty, or ob handed off this cycle with out_ready=1).
//  flush in IDLE is ignored. flush held in HOLD forces DRAIN on the next edge.
//  Simultaneous read and write: level unchanged; pointers both advance.
//  level and pointer arithmetic are modulo 2*DEPTH on the wrap-bit pointers; level = wr_ptr - rd_ptr.
// STRUCTURE
//  usb_uart_defs.vh (shared): FSM state encodings (ST_IDLE=2'd0, ST_HOLD=2'd1, ST_DRAIN=2'd2), USB_FS_BULK_MAX=64.
//  One sub-module: usb_uart_fifo_ram (DEPTH x 8 simple dual-port RAM, sync write, async read), inferred as LUT RAM/EBR.
//  Pointers, FSM, timer and output register live in this module.
//  Target size is roughly 150-250 lines.
// TESTING
//  1. THRESHOLD=4: write 8'h41..8'h43, out_ready=1 -> out_valid stays 0 for TIMEOUT-1 idle cycles, then 41,42,43 in order, state back to IDLE.
//  2. THRESHOLD=4: write 41..44 back-to-back -> out_valid rises 1 cycle after the 4th write and bytes stream 1/cycle.
//  3. DEPTH=8, out_ready=0, write 9 bytes -> in_ready=0 after the 8th (level=8) byte, or after the 9th if one byte already moved to ob.
//     Raise out_ready -> all bytes emerge in order, none lost or duplicated.
//  4. Backpressure: toggle out_ready randomly during drain -> out_data never changes while out_valid&&!out_ready.
//  5. Write 1 byte, flush=1 next cycle -> state HOLD->DRAIN; out_valid=1 two cycles after flush; flush in IDLE does nothing.
//  6. reset=0 mid-drain with level=5 -> next edge level=0, out_valid=0; after release, new bytes are output, old ones are not.

Source files
------------

// File: rtl/usb_uart_tx_batcher_pkg.sv
// Shared definitions for the USB-UART device->host byte batcher.
//   batch_state_e : batching FSM states (idle / holding for a batch / draining a burst)
//   UsbFsBulkMax  : full-speed bulk endpoint max packet size, the natural FIFO depth
package usb_uart_tx_batcher_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } batch_state_e;

  localparam int unsigned UsbFsBulkMax = 64;

endpackage

// File: rtl/usb_uart_tx_batcher_fifo_ram.sv
// Depth x 8 simple dual-port storage for the batcher FIFO.
// Synchronous write, asynchronous read, so it maps onto LUT RAM / EBR.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write byte
//   raddr_i : read address
//   rdata_o : read byte (combinational from raddr_i)
module usb_uart_tx_batcher_fifo_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_uart_tx_batcher.sv
// Byte FIFO and packet-batching stage feeding usb_uart's uart_in_* stream (device->host).
// Bytes are buffered and released in bursts when the fill level reaches THRESHOLD, when no
// write has arrived for TIMEOUT cycles, or when flush is held.
//   clk_48mhz : sole clock
//   reset     : synchronous, active-low
//   in_data / in_valid / in_ready    : byte stream from user logic
//   flush     : level-sensitive request to drain now
//   out_data / out_valid / out_ready : registered byte stream to usb_uart.uart_in_*
//   level     : FIFO occupancy, not counting the byte held in the output register
module usb_uart_tx_batcher
  import usb_uart_tx_batcher_pkg::*;
#(
  parameter int unsigned DEPTH     = UsbFsBulkMax,
  parameter int unsigned THRESHOLD = 32,
  parameter int unsigned TIMEOUT   = 48000
) (
  input  logic                     clk_48mhz,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam int unsigned Lw = Aw + 1;
  localparam int unsigned Tw = $clog2(TIMEOUT + 1);

  localparam logic [Lw-1:0] FullLvl   = Lw'(DEPTH);
  localparam logic [Lw-1:0] ThreshLvl = Lw'(THRESHOLD);
  localparam logic [Tw-1:0] TimerLast = Tw'(TIMEOUT - 1);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [Aw:0]   wr_ptr_q, wr_ptr_d;
  logic [Aw:0]   rd_ptr_q, rd_ptr_d;
  logic [Tw-1:0] timer_q, timer_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  batch_state_e  state_q, state_d;

  logic [Lw-1:0] level_q;
  logic [Lw-1:0] level_d;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          ob_load;
  logic [7:0]    rdata;

  assign level_q = wr_ptr_q - rd_ptr_q;
  assign full    = (level_q == FullLvl);
  assign empty   = (level_q == '0);

  // No write-through: a full FIFO refuses even when a read happens this cycle.
  assign in_ready = reset & ~full;
  assign wr_en    = in_valid & in_ready;

  // The output register refills whenever it is empty or being handed off this cycle.
  assign ob_load = (state_q == StDrain) && !empty && (!out_valid_q || out_ready);

  usb_uart_tx_batcher_fifo_ram #(
    .Depth (DEPTH),
    .Aw    (Aw)
  ) u_ram (
    .clk_i   (clk_48mhz),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[Aw-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q[Aw-1:0]),
    .rdata_o (rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{Aw{1'b0}}, wr_en};
    rd_ptr_d    = rd_ptr_q + {{Aw{1'b0}}, ob_load};
    level_d     = wr_ptr_d - rd_ptr_d;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (ob_load) begin
      out_data_d  = rdata;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (wr_en) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (wr_en) begin
          timer_d = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
        // Threshold uses the occupancy after this edge's write.
        if ((level_d >= ThreshLvl) || (!wr_en && (timer_q == TimerLast)) || flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        timer_d = '0;
        if (empty && !wr_en && (!out_valid_q || out_ready)) begin
          state_d = StIdle;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      timer_q     <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      state_q     <= StIdle;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      timer_q     <= timer_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;

endmodule

// File: tb/tb_usb_uart_tx_batcher.sv
// Directed self-checking bench for usb_uart_tx_batcher (DEPTH=8, THRESHOLD=4, TIMEOUT=20).
module tb_usb_uart_tx_batcher;
  import usb_uart_tx_batcher_pkg::*;

  localparam int unsigned Depth = 8;
  localparam int unsigned Thr   = 4;
  localparam int unsigned To    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  usb_uart_tx_batcher #(
    .DEPTH     (Depth),
    .THRESHOLD (Thr),
    .TIMEOUT   (To)
  ) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();

    // Reset state
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'h00);
    chk("rst state", 32'(dut.state_q), 32'(StIdle));
    reset = 1'b1;
    #1;
    chk("rel in_ready", 32'(in_ready), 32'd1);

    // 1: three bytes below threshold drain only after the idle timeout
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h41 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("t1 state hold", 32'(dut.state_q), 32'(StHold));
    chk("t1 level", 32'(level), 32'd3);
    for (int k = 1; k < int'(To); k++) begin
      cyc();
      chk("t1 wait valid", 32'(out_valid), 32'd0);
      chk("t1 wait state", 32'(dut.state_q), 32'(StHold));
    end
    cyc();
    chk("t1 to drain", 32'(dut.state_q), 32'(StDrain));
    chk("t1 drain valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1 out_valid", 32'(out_valid), 32'd1);
      chk("t1 out_data", 32'(out_data), 32'h41 + 32'(i));
      chk("t1 level", 32'(level), 32'(2 - i));
    end
    cyc();
    chk("t1 end valid", 32'(out_valid), 32'd0);
    chk("t1 end state", 32'(dut.state_q), 32'(StIdle));

    // 2: reaching the threshold starts an immediate 1 byte/cycle burst
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h41 + 8'(i);
      cyc();
      chk("t2 fill valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk("t2 state drain", 32'(dut.state_q), 32'(StDrain));
    chk("t2 level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2 out_valid", 32'(out_valid), 32'd1);
      chk("t2 out_data", 32'(out_data), 32'h41 + 32'(i));
    end
    cyc();
    chk("t2 end valid", 32'(out_valid), 32'd0);
    chk("t2 end state", 32'(dut.state_q), 32'(StIdle));

    // 3: fill to full with the sink stalled; one byte sits in the output register
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("t3 in_ready before write", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 8'h50 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("t3 full in_ready", 32'(in_ready), 32'd0);
    chk("t3 full level", 32'(level), 32'd8);
    chk("t3 ob valid", 32'(out_valid), 32'd1);
    chk("t3 ob data", 32'(out_data), 32'h50);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 9; c++) begin
      if (out_valid) begin
        chk("t3 out_data", 32'(out_data), 32'h50 + 32'(n));
        n++;
      end
      cyc();
    end
    chk("t3 byte count", 32'(n), 32'd9);
    chk("t3 end valid", 32'(out_valid), 32'd0);
    chk("t3 end level", 32'(level), 32'd0);
    chk("t3 end state", 32'(dut.state_q), 32'(StIdle));

    // 4: random backpressure; the pending byte must stay put until taken
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 300 && n < 8; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid) begin
        chk("t4 out_data", 32'(out_data), 32'h60 + 32'(n));
        if (out_ready) n++;
      end
      cyc();
    end
    out_ready = 1'b1;
    chk("t4 byte count", 32'(n), 32'd8);
    chk("t4 end valid", 32'(out_valid), 32'd0);
    chk("t4 end state", 32'(dut.state_q), 32'(StIdle));

    // 5: flush ignored in IDLE, honoured in HOLD
    flush = 1'b1;
    cyc();
    cyc();
    chk("t5 idle flush state", 32'(dut.state_q), 32'(StIdle));
    chk("t5 idle flush valid", 32'(out_valid), 32'd0);
    chk("t5 idle flush level", 32'(level), 32'd0);
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h70;
    cyc();
    in_valid = 1'b0;
    flush    = 1'b1;
    chk("t5 hold", 32'(dut.state_q), 32'(StHold));
    cyc();
    flush = 1'b0;
    chk("t5 flush drain", 32'(dut.state_q), 32'(StDrain));
    chk("t5 flush valid early", 32'(out_valid), 32'd0);
    cyc();
    chk("t5 flush valid", 32'(out_valid), 32'd1);
    chk("t5 flush data", 32'(out_data), 32'h70);
    cyc();
    chk("t5 end valid", 32'(out_valid), 32'd0);
    chk("t5 end state", 32'(dut.state_q), 32'(StIdle));

    // 6: reset mid-drain discards everything
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h80 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("t6 pre level", 32'(level), 32'd5);
    chk("t6 pre valid", 32'(out_valid), 32'd1);
    chk("t6 pre state", 32'(dut.state_q), 32'(StDrain));
    reset = 1'b0;
    cyc();
    chk("t6 rst level", 32'(level), 32'd0);
    chk("t6 rst valid", 32'(out_valid), 32'd0);
    chk("t6 rst data", 32'(out_data), 32'h00);
    chk("t6 rst in_ready", 32'(in_ready), 32'd0);
    chk("t6 rst state", 32'(dut.state_q), 32'(StIdle));
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h90 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (out_valid) begin
        chk("t6 out_data", 32'(out_data), 32'h90 + 32'(n));
        n++;
      end
      cyc();
    end
    chk("t6 byte count", 32'(n), 32'd4);
    chk("t6 end valid", 32'(out_valid), 32'd0);
    chk("t6 end state", 32'(dut.state_q), 32'(StIdle));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
